div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_pkg.sv | 5 +
 rtl/div_step.sv | 18 +
 rtl/div_sequencer.sv | 107 ++++++++++
 tb/tb_div_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default operand width for the divider
package div_pkg;
    localparam int DIV_WIDTH = 32;
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational non-restoring division iteration on {A,Q} with divisor M
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH:0] sh;
    assign sh = {a[WIDTH-1:0], q[WIDTH-1]};
    // subtract while the partial remainder is non-negative, add back otherwise
    always_comb begin
        a_next = a[WIDTH] ? sh + {1'b0, m} : sh - {1'b0, m};
        q_next = {q[WIDTH-2:0], ~a_next[WIDTH]};
    end
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle signed non-restoring divider; DIV_SEQUENCER_DZ_TRAP_EN short-circuits divide-by-zero
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz_err
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t           state, next;
    logic [WIDTH:0]   a, a_step;
    logic [WIDTH-1:0] q, q_step, m, dvd, dvs, a_fix;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r;
    div_step #(.WIDTH(WIDTH)) u_step (.a(a), .q(q), .m(m), .a_next(a_step), .q_next(q_step));
    assign a_fix = a[WIDTH] ? a[WIDTH-1:0] + m : a[WIDTH-1:0];
    assign busy  = state == PREP || state == ITER || state == FIX;
    assign done  = state == DONE;
`ifdef DIV_SEQUENCER_DZ_TRAP_EN
    logic dz, dz_q;
    assign dz     = divisor == '0;
    assign dz_err = dz_q;
`else
    assign dz_err = 1'b0;
`endif
    // state register
    always_ff @(posedge clock) begin
        state <= clear ? IDLE : next;
    end
    // next-state selection
    always_comb begin
        next = state;
        unique case (state)
`ifdef DIV_SEQUENCER_DZ_TRAP_EN
            IDLE:    next = start ? (dz ? DONE : PREP) : IDLE;
`else
            IDLE:    next = start ? PREP : IDLE;
`endif
            PREP:    next = ITER;
            ITER:    next = cnt == CW'(1) ? FIX : ITER;
            FIX:     next = DONE;
            default: next = IDLE;
        endcase
    end
    // operand capture, iteration datapath and result registers
    always_ff @(posedge clock) begin
        if (clear) begin
            a         <= '0;
            q         <= '0;
            m         <= '0;
            dvd       <= '0;
            dvs       <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_SEQUENCER_DZ_TRAP_EN
            dz_q      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    dvd <= dividend;
                    dvs <= divisor;
`ifdef DIV_SEQUENCER_DZ_TRAP_EN
                    if (dz) begin
                        quotient  <= '0;
                        remainder <= dividend;
                        dz_q      <= 1'b1;
                    end
`endif
                end
                PREP: begin
                    a     <= '0;
                    q     <= dvd[WIDTH-1] ? -dvd : dvd;
                    m     <= dvs[WIDTH-1] ? -dvs : dvs;
                    neg_q <= dvd[WIDTH-1] ^ dvs[WIDTH-1];
                    neg_r <= dvd[WIDTH-1];
                    cnt   <= CW'(WIDTH);
                end
                ITER: begin
                    a   <= a_step;
                    q   <= q_step;
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    quotient  <= neg_q ? -q : q;
                    remainder <= neg_r ? -a_fix : a_fix;
`ifdef DIV_SEQUENCER_DZ_TRAP_EN
                    dz_q      <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed self-checking bench for div_sequencer; expectations follow DIV_SEQUENCER_DZ_TRAP_EN
module tb_div_sequencer;
    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, dz_err;
    logic [31:0] quotient, remainder;
    int checks = 0;
    int failures = 0;

    div_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dz_err(dz_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz, input int elat);
        int n;
        n = 0;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        while (n < 200) begin
            tick();
            n++;
            if (n == 1) start = 1'b0;
            if (done) break;
        end
        chk({tag, "_lat"}, n, elat);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dz"}, {31'b0, dz_err}, {31'b0, edz});
        tick();
        chk({tag, "_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int n, dones, first;
        tick();
        tick();
        clear = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_dz", {31'b0, dz_err}, 32'd0);

        run("p100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35);
        run("m100_7", -32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 35);
        run("p100_m7", 32'd100, -32'sd7, 32'hFFFFFFF2, 32'd2, 1'b0, 35);
        run("min_m1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 35);
`ifdef DIV_SEQUENCER_DZ_TRAP_EN
        run("dz5", 32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1);
`else
        run("dz5", 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b0, 35);
`endif

        // a second start mid-operation must be dropped
        dividend = 32'd50;
        divisor  = 32'd6;
        start    = 1'b1;
        n = 0;
        dones = 0;
        first = 0;
        while (n < 80) begin
            tick();
            n++;
            if (n == 1) start = 1'b0;
            if (n == 9) begin
                dividend = 32'd77;
                divisor  = 32'd5;
                start    = 1'b1;
            end
            if (n == 10) start = 1'b0;
            if (done) begin
                dones++;
                if (first == 0) begin
                    first = n;
                    chk("ign_q", quotient, 32'd8);
                    chk("ign_r", remainder, 32'd2);
                end
            end
        end
        chk("ign_dones", dones, 32'd1);
        chk("ign_lat", first, 32'd35);

        // clear in the middle of iteration
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        n = 0;
        while (n < 11) begin
            tick();
            n++;
            if (n == 1) start = 1'b0;
        end
        chk("clr_pre_busy", {31'b0, busy}, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_busy", {31'b0, busy}, 32'd0);
        chk("clr_done", {31'b0, done}, 32'd0);
        chk("clr_q", quotient, 32'd0);
        chk("clr_r", remainder, 32'd0);
        chk("clr_dz", {31'b0, dz_err}, 32'd0);
        run("p9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 35);

        // start held high relaunches on the first IDLE cycle after DONE
        dividend = 32'd20;
        divisor  = 32'd4;
        start    = 1'b1;
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (done) break;
        end
        chk("hold_lat1", n, 32'd35);
        chk("hold_q1", quotient, 32'd5);
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (done) break;
        end
        start = 1'b0;
        chk("hold_lat2", n, 32'd36);
        chk("hold_r2", remainder, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
